// File: rtl/imem_loader_ctrl_if.sv
// Host byte channel, load/run control and instruction-memory write port of the loader.
interface imem_loader_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              start_load;
  logic [7:0]        load_len;
  logic              start_run;
  logic              abort;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_stall;
  logic              load_done;
  logic              load_err;
  logic [1:0]        state_dbg;

  // Byte handshake: a byte transfers on a rising edge where byte_valid & byte_ready;
  // byte_valid may rise or fall freely, a byte offered while byte_ready=0 stays with the host.
  modport master (
    output start_load, load_len, start_run, abort, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_waddr, imem_wdata, cpu_stall, load_done, load_err,
    input  state_dbg
  );

  modport slave (
    input  start_load, load_len, start_run, abort, byte_in, byte_valid,
    output byte_ready, imem_we, imem_waddr, imem_wdata, cpu_stall, load_done, load_err,
    output state_dbg
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Loads a program into instruction memory from a byte stream (little-endian words) and
// holds the core's fetch stalled until the load has finished or a run is requested.
module imem_loader_ctrl #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  imem_loader_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  state_t            state_q, state_d;
  logic [7:0]        len_q;
  logic [ADDR_W-1:0] word_cnt_q;
  logic [1:0]        lane_q;
  logic [23:0]       lane_buf_q;
  logic [31:0]       wdata_q;
  logic              load_err_q;
  logic              load_done_q;

  logic len_ok;
  logic load_req;
  logic accept_load;
  logic reject_load;
  logic byte_fire;
  logic last_byte;
  logic last_word;
  logic busy_abort;
  logic write_ok;

  always_comb begin
    len_ok      = (bus.load_len != 8'd0) && ({1'b0, bus.load_len} <= DEPTH_L);
    load_req    = bus.start_load && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    accept_load = load_req && len_ok;
    reject_load = load_req && !len_ok;
    busy_abort  = bus.abort && ((state_q == ST_LOAD) || (state_q == ST_WRITE));
    byte_fire   = bus.byte_valid && (state_q == ST_LOAD) && !bus.abort;
    last_byte   = byte_fire && (lane_q == 2'd3);
    last_word   = ({{(8-ADDR_W){1'b0}}, word_cnt_q} == (len_q - 8'd1));
    write_ok    = (state_q == ST_WRITE) && !bus.abort;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // start_load wins over start_run even when its length is rejected
        if (accept_load)                         state_d = ST_LOAD;
        else if (!bus.start_load && bus.start_run) state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (bus.abort)      state_d = ST_IDLE;
        else if (last_byte) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.abort)      state_d = ST_IDLE;
        else if (last_word) state_d = ST_RUN;
        else                state_d = ST_LOAD;
      end
      ST_RUN: begin
        if (accept_load) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= 8'd0;
      word_cnt_q <= '0;
      lane_q     <= 2'd0;
      lane_buf_q <= 24'd0;
      wdata_q    <= 32'd0;
    end else begin
      if (accept_load) begin
        len_q      <= bus.load_len;
        word_cnt_q <= '0;
        lane_q     <= 2'd0;
      end else if (busy_abort) begin
        word_cnt_q <= '0;
        lane_q     <= 2'd0;
      end else begin
        if (byte_fire) begin
          lane_q <= lane_q + 2'd1;
          case (lane_q)
            2'd0:    lane_buf_q[7:0]   <= bus.byte_in;
            2'd1:    lane_buf_q[15:8]  <= bus.byte_in;
            2'd2:    lane_buf_q[23:16] <= bus.byte_in;
            default: wdata_q           <= {bus.byte_in, lane_buf_q};
          endcase
        end
        if (write_ok && !last_word) word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_err_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      if (accept_load)      load_err_q <= 1'b0;
      else if (reject_load) load_err_q <= 1'b1;
      // registered so it lines up with the first RUN cycle after the final write
      load_done_q <= write_ok && last_word;
    end
  end

  always_comb begin
    bus.byte_ready = (state_q == ST_LOAD);
    bus.imem_we    = write_ok;
    bus.imem_waddr = word_cnt_q;
    bus.imem_wdata = wdata_q;
    bus.cpu_stall  = (state_q != ST_RUN);
    bus.load_done  = load_done_q;
    bus.load_err   = load_err_q;
    bus.state_dbg  = state_q;
  end

endmodule
